// File: rtl/pico_cpu_mc_if.sv
// pico_cpu_mc_if: bus bundle for the picoMIPS gen-3 core.
// Carries instruction fetch, ready/valid input port, ready/valid output port and busy.
// The master modport is the core side; the slave modport is the memory/board side.
interface pico_cpu_mc_if #(
    parameter int N      = 8,
    parameter int P_SIZE = 5,
    parameter int I_SIZE = 16
);
    logic [P_SIZE-1:0] imem_addr;
    logic [I_SIZE-1:0] imem_data;
    logic [N-1:0]      in_data;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport master (
        output imem_addr,
        input  imem_data,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output busy
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  busy
    );
endinterface

// File: rtl/pico_cpu_mc.sv
// pico_cpu_mc: picoMIPS generation-3 multi-cycle CPU.
// Register file, zero flag, ready/valid I/O ports, external combinational instruction memory.
// Build macro PICO_HW_MUL_EN: when defined, MUL completes in one RUN cycle through a
// combinational multiplier; when undefined, MUL runs an N-cycle shift-add in the MUL state.
module pico_cpu_mc #(
    parameter int N      = 8,
    parameter int P_SIZE = 5,
    parameter int I_SIZE = 16,
    parameter int NREGS  = 8
) (
    input  logic          clk,
    input  logic          n_reset,
    pico_cpu_mc_if.master bus
);
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_IN   = 3'd4;
    localparam logic [2:0] OP_OUT  = 3'd5;
    localparam logic [2:0] OP_BZ   = 3'd6;

    typedef enum logic [1:0] {RUN, MUL, WAIT_IN, WAIT_OUT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [P_SIZE-1:0] pc;
    logic [P_SIZE-1:0] pc_nxt;
    logic [P_SIZE-1:0] pc_inc;
    logic [N-1:0]      regs [0:7];
    logic              z;
    logic [N-1:0]      out_data_r;
    logic              out_valid_r;

    // Instruction fields; imm and tgt overlap other fields by design of the encoding.
    logic [2:0]        op;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [N-1:0]      imm;
    logic [P_SIZE-1:0] tgt;
    logic [N-1:0]      a_val;
    logic [N-1:0]      b_val;

    // Control produced by the next-state logic.
    logic              wr_en;
    logic [2:0]        wr_idx;
    logic [N-1:0]      wr_val;
    logic              z_we;
    logic              out_load;
    logic              mul_start;
    logic              in_ready;

`ifdef PICO_HW_MUL_EN
`else
    localparam int CW = $clog2(N);
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic [N-1:0]      mul_acc;
    logic [CW-1:0]     mul_cnt;
    logic [2:0]        mul_rd;
    logic              mul_last;
    assign mul_last = (mul_cnt == CW'(N - 1));
`endif

    assign op     = bus.imem_data[15:13];
    assign rd     = bus.imem_data[12:10];
    assign rs     = bus.imem_data[9:7];
    assign imm    = N'(bus.imem_data[7:0]);
    assign tgt    = bus.imem_data[P_SIZE-1:0];
    assign pc_inc = pc + P_SIZE'(1);

    // R0 and indices beyond the implemented register count read as zero.
    assign a_val = (rd == 3'd0 || int'(rd) >= NREGS) ? '0 : regs[rd];
    assign b_val = (rs == 3'd0 || int'(rs) >= NREGS) ? '0 : regs[rs];

    assign bus.imem_addr = pc;
    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = (state != RUN);

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= RUN;
        else          state <= state_nxt;
    end

    // Next-state, PC and write-back decisions for the current state and instruction
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        wr_en     = 1'b0;
        wr_idx    = rd;
        wr_val    = '0;
        z_we      = 1'b0;
        out_load  = 1'b0;
        mul_start = 1'b0;
        in_ready  = 1'b0;
        case (state)
            RUN: begin
                case (op)
                    OP_NOP: pc_nxt = pc_inc;
                    OP_ADD: begin
                        wr_en  = 1'b1;
                        wr_val = a_val + b_val;
                        z_we   = 1'b1;
                        pc_nxt = pc_inc;
                    end
                    OP_ADDI: begin
                        wr_en  = 1'b1;
                        wr_val = a_val + imm;
                        z_we   = 1'b1;
                        pc_nxt = pc_inc;
                    end
                    OP_MUL: begin
`ifdef PICO_HW_MUL_EN
                        wr_en  = 1'b1;
                        wr_val = a_val * b_val;
                        z_we   = 1'b1;
                        pc_nxt = pc_inc;
`else
                        mul_start = 1'b1;
                        state_nxt = MUL;
`endif
                    end
                    OP_IN: state_nxt = WAIT_IN;
                    OP_OUT: begin
                        // A pending value being taken this cycle frees the slot immediately.
                        if (!out_valid_r || bus.out_ready) begin
                            out_load = 1'b1;
                            pc_nxt   = pc_inc;
                        end else begin
                            state_nxt = WAIT_OUT;
                        end
                    end
                    OP_BZ:   pc_nxt = z ? tgt : pc_inc;
                    default: pc_nxt = tgt;
                endcase
            end
            MUL: begin
`ifdef PICO_HW_MUL_EN
                state_nxt = RUN;
`else
                if (mul_last) begin
                    wr_en     = 1'b1;
                    wr_idx    = mul_rd;
                    wr_val    = mul_acc + (mul_b[0] ? mul_a : '0);
                    z_we      = 1'b1;
                    pc_nxt    = pc_inc;
                    state_nxt = RUN;
                end
`endif
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    wr_en     = 1'b1;
                    wr_val    = bus.in_data;
                    pc_nxt    = pc_inc;
                    state_nxt = RUN;
                end
            end
            default: begin
                if (bus.out_ready) begin
                    out_load  = 1'b1;
                    pc_nxt    = pc_inc;
                    state_nxt = RUN;
                end
            end
        endcase
    end

    // Architectural state: PC, register file, zero flag and output port
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pc          <= '0;
            z           <= 1'b0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            pc <= pc_nxt;
            if (wr_en && wr_idx != 3'd0 && int'(wr_idx) < NREGS) regs[wr_idx] <= wr_val;
            if (z_we) z <= (wr_val == '0);
            if (out_load) begin
                out_data_r  <= b_val;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

`ifdef PICO_HW_MUL_EN
`else
    // Shift-add multiplier: one multiplier bit per MUL cycle, low N bits kept
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            mul_cnt <= '0;
            mul_rd  <= '0;
        end else if (mul_start) begin
            mul_a   <= a_val;
            mul_b   <= b_val;
            mul_acc <= '0;
            mul_cnt <= '0;
            mul_rd  <= rd;
        end else if (state == MUL) begin
            if (mul_b[0]) mul_acc <= mul_acc + mul_a;
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_cnt <= mul_cnt + CW'(1);
        end
    end
`endif
endmodule

// File: tb/tb_pico_cpu_mc.sv
// tb_pico_cpu_mc: directed scenarios plus randomized programs checked against an
// instruction-level reference interpreter of the picoMIPS gen-3 ISA.
module tb_pico_cpu_mc;
    localparam int N      = 8;
    localparam int P_SIZE = 5;
    localparam int I_SIZE = 16;
    localparam int NREGS  = 8;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_IN  = 3'd4;
    localparam logic [2:0] OP_OUT = 3'd5;
    localparam logic [2:0] OP_BZ  = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;
`ifdef PICO_HW_MUL_EN
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_BUSY = N;
`endif

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    pico_cpu_mc_if #(.N(N), .P_SIZE(P_SIZE), .I_SIZE(I_SIZE)) bus_if ();
    pico_cpu_mc #(.N(N), .P_SIZE(P_SIZE), .I_SIZE(I_SIZE), .NREGS(NREGS)) dut (
        .clk(clk), .n_reset(n_reset), .bus(bus_if)
    );

    logic [15:0] imem [0:31];
    assign bus_if.imem_data = imem[bus_if.imem_addr];

    int total = 0;
    int bad   = 0;
    logic [7:0] in_vals [0:4095];
    logic [7:0] exp_q [$];
    logic [7:0] act_q [$];

    function automatic logic [15:0] rr(input logic [2:0] op, input int d, input int s);
        logic [2:0] dd;
        logic [2:0] ss;
        dd = d[2:0];
        ss = s[2:0];
        return {op, dd, ss, 7'd0};
    endfunction

    function automatic logic [15:0] addi(input int d, input int imm);
        logic [2:0] dd;
        logic [7:0] ii;
        dd = d[2:0];
        ii = imm[7:0];
        return {3'b010, dd, 2'b00, ii};
    endfunction

    function automatic logic [15:0] br(input logic [2:0] op, input int t);
        logic [4:0] tt;
        tt = t[4:0];
        return {op, 8'd0, tt};
    endfunction

    task automatic clear_prog;
        for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset for two edges, release 1 time unit after an edge (sample point s0).
    task automatic start;
        n_reset = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
    endtask

    task automatic test_reset;
        clear_prog();
        n_reset = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus_if.imem_addr !== 5'd0) begin bad++; $display("FAIL rst_pc got=%0d want=0", bus_if.imem_addr); end
        total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus_if.busy); end
        total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", bus_if.in_ready); end
        total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus_if.out_valid); end
        total++; if (bus_if.out_data !== 8'd0) begin bad++; $display("FAIL rst_out_data got=%0d want=0", bus_if.out_data); end
    endtask

    task automatic test_add_bz;
        int exp_pc [5] = '{1, 2, 3, 7, 8};
        clear_prog();
        imem[0] = addi(1, 5);
        imem[1] = addi(2, 251);
        imem[2] = rr(OP_ADD, 1, 2);
        imem[3] = br(OP_BZ, 7);
        imem[7] = rr(OP_OUT, 0, 1);
        imem[8] = br(OP_JMP, 8);
        start();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus_if.imem_addr !== 5'(exp_pc[i])) begin
                bad++; $display("FAIL add_bz_pc step=%0d got=%0d want=%0d", i, bus_if.imem_addr, exp_pc[i]);
            end
        end
        total++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'd0) begin
            bad++; $display("FAIL add_wrap_out got=%b/%0d want=1/0", bus_if.out_valid, bus_if.out_data);
        end
    endtask

    task automatic test_mul;
        int busy_cnt = 0;
        clear_prog();
        imem[0] = addi(1, 13);
        imem[1] = addi(2, 11);
        imem[2] = rr(OP_MUL, 1, 2);
        imem[3] = br(OP_BZ, 9);
        imem[4] = rr(OP_OUT, 0, 1);
        imem[5] = br(OP_JMP, 5);
        start();
        tick(); tick();
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus_if.busy) busy_cnt++;
        end
        total++; if (busy_cnt != MUL_BUSY) begin bad++; $display("FAIL mul_busy got=%0d want=%0d", busy_cnt, MUL_BUSY); end
        total++; if (bus_if.out_data !== 8'd143) begin bad++; $display("FAIL mul_result got=%0d want=143", bus_if.out_data); end
        total++; if (bus_if.imem_addr !== 5'd5) begin bad++; $display("FAIL mul_pc got=%0d want=5", bus_if.imem_addr); end
    endtask

    task automatic test_in;
        int ready_cnt = 0;
        clear_prog();
        imem[0] = rr(OP_IN, 3, 0);
        imem[1] = rr(OP_OUT, 0, 3);
        imem[2] = br(OP_JMP, 2);
        start();
        // Offered while the core is still in RUN: must not be taken.
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'h33;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus_if.in_ready) ready_cnt++;
            if (c == 3) begin
                total++; if (bus_if.imem_addr !== 5'd0) begin bad++; $display("FAIL in_pc_hold got=%0d want=0", bus_if.imem_addr); end
            end
            if (c == 6) begin
                total++; if (bus_if.imem_addr !== 5'd1) begin bad++; $display("FAIL in_pc_adv got=%0d want=1", bus_if.imem_addr); end
            end
            if (c == 5) begin
                bus_if.in_valid = 1'b1;
                bus_if.in_data  = 8'h5A;
            end else begin
                bus_if.in_valid = 1'b0;
                bus_if.in_data  = 8'h00;
            end
        end
        total++; if (ready_cnt != 5) begin bad++; $display("FAIL in_ready_cycles got=%0d want=5", ready_cnt); end
        total++; if (bus_if.out_data !== 8'h5A) begin bad++; $display("FAIL in_value got=%h want=5a", bus_if.out_data); end
        total++; if (bus_if.imem_addr !== 5'd2) begin bad++; $display("FAIL in_final_pc got=%0d want=2", bus_if.imem_addr); end
    endtask

    task automatic test_out_stall;
        clear_prog();
        imem[0] = addi(1, 7);
        imem[1] = rr(OP_OUT, 0, 1);
        imem[2] = addi(1, 9);
        imem[3] = rr(OP_OUT, 0, 1);
        imem[4] = br(OP_JMP, 4);
        start();
        tick(); tick();
        total++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'd7) begin
            bad++; $display("FAIL out_first got=%b/%0d want=1/7", bus_if.out_valid, bus_if.out_data);
        end
        for (int c = 0; c < 5; c++) tick();
        total++; if (bus_if.busy !== 1'b1 || bus_if.imem_addr !== 5'd3 || bus_if.out_data !== 8'd7) begin
            bad++; $display("FAIL out_stall got=busy%b pc%0d data%0d want=busy1 pc3 data7", bus_if.busy, bus_if.imem_addr, bus_if.out_data);
        end
        bus_if.out_ready = 1'b1;
        tick();
        total++; if (bus_if.busy !== 1'b0 || bus_if.imem_addr !== 5'd4 || bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'd16) begin
            bad++; $display("FAIL out_second got=busy%b pc%0d v%b data%0d want=busy0 pc4 v1 data16", bus_if.busy, bus_if.imem_addr, bus_if.out_valid, bus_if.out_data);
        end
        tick();
        total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL out_clear got=%b want=0", bus_if.out_valid); end
    endtask

    task automatic test_jmp_wrap;
        int exp_pc [6] = '{1, 2, 29, 30, 31, 0};
        clear_prog();
        imem[0]  = addi(1, 77);
        imem[1]  = rr(OP_OUT, 0, 1);
        imem[2]  = br(OP_JMP, 29);
        imem[29] = addi(0, 9);
        imem[30] = rr(OP_OUT, 0, 0);
        imem[31] = 16'h0000;
        start();
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (bus_if.imem_addr !== 5'(exp_pc[i])) begin
                bad++; $display("FAIL wrap_pc step=%0d got=%0d want=%0d", i, bus_if.imem_addr, exp_pc[i]);
            end
            if (i == 1) begin
                total++; if (bus_if.out_data !== 8'd77) begin bad++; $display("FAIL wrap_out77 got=%0d want=77", bus_if.out_data); end
            end
            if (i == 4) begin
                total++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'd0) begin
                    bad++; $display("FAIL r0_reads_zero got=%b/%0d want=1/0", bus_if.out_valid, bus_if.out_data);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mul;
        clear_prog();
        imem[0] = addi(1, 3);
        imem[1] = rr(OP_OUT, 0, 1);
        imem[2] = addi(2, 5);
        imem[3] = rr(OP_MUL, 1, 2);
        imem[4] = rr(OP_OUT, 0, 1);
        imem[5] = br(OP_JMP, 5);
        start();
        for (int c = 0; c < 7; c++) tick();
        total++; if (bus_if.busy !== 1'b1 || bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'd3) begin
            bad++; $display("FAIL pre_reset got=busy%b v%b data%0d want=busy1 v1 data3", bus_if.busy, bus_if.out_valid, bus_if.out_data);
        end
        n_reset = 1'b0;
        #1;
        total++; if (bus_if.imem_addr !== 5'd0 || bus_if.busy !== 1'b0 || bus_if.in_ready !== 1'b0) begin
            bad++; $display("FAIL async_rst_ctl got=pc%0d busy%b rdy%b want=pc0 busy0 rdy0", bus_if.imem_addr, bus_if.busy, bus_if.in_ready);
        end
        total++; if (bus_if.out_valid !== 1'b0 || bus_if.out_data !== 8'd0) begin
            bad++; $display("FAIL async_rst_out got=%b/%0d want=0/0", bus_if.out_valid, bus_if.out_data);
        end
        clear_prog();
        imem[0] = addi(1, 1);
        imem[1] = rr(OP_OUT, 0, 1);
        imem[2] = br(OP_JMP, 2);
        start();
        tick(); tick();
        total++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'd1) begin
            bad++; $display("FAIL post_reset_regs got=%b/%0d want=1/1", bus_if.out_valid, bus_if.out_data);
        end
    endtask

    // Instruction-level interpreter: executes the program in imem and records OUT values.
    task automatic model_run;
        int r [8];
        int zf = 0;
        int pc = 0;
        int ii = 0;
        int res;
        logic [15:0] w;
        int op, d, s;
        for (int i = 0; i < 8; i++) r[i] = 0;
        exp_q.delete();
        for (int k = 0; k < 3000; k++) begin
            w  = imem[pc];
            op = int'(w[15:13]);
            d  = int'(w[12:10]);
            s  = int'(w[9:7]);
            case (op)
                0: pc = (pc + 1) % 32;
                1, 2, 3: begin
                    if (op == 1)      res = (r[d] + r[s]) % 256;
                    else if (op == 2) res = (r[d] + int'(w[7:0])) % 256;
                    else              res = (r[d] * r[s]) % 256;
                    if (d != 0) r[d] = res;
                    zf = (res == 0) ? 1 : 0;
                    pc = (pc + 1) % 32;
                end
                4: begin
                    if (d != 0) r[d] = int'(in_vals[ii]);
                    ii++;
                    pc = (pc + 1) % 32;
                end
                5: begin
                    exp_q.push_back(8'(r[s]));
                    pc = (pc + 1) % 32;
                end
                6: pc = (zf != 0) ? int'(w[4:0]) : (pc + 1) % 32;
                default: pc = int'(w[4:0]);
            endcase
        end
    endtask

    task automatic test_random;
        int ii;
        for (int run = 0; run < 4; run++) begin
            for (int i = 0; i < 32; i++) imem[i] = 16'($urandom_range(0, 65535));
            // Bias toward I/O so each program produces a useful output stream.
            for (int i = 0; i < 32; i += 4) imem[i] = rr(OP_OUT, 0, $urandom_range(0, 7));
            imem[31] = br(OP_JMP, 0);
            for (int i = 0; i < 4096; i++) in_vals[i] = 8'($urandom_range(0, 255));
            model_run();
            act_q.delete();
            ii = 0;
            start();
            for (int c = 0; c < 700; c++) begin
                bus_if.in_valid  = ($urandom_range(0, 1) == 1);
                bus_if.in_data   = in_vals[ii];
                bus_if.out_ready = ($urandom_range(0, 3) != 0);
                if (bus_if.in_ready && bus_if.in_valid) ii++;
                if (bus_if.out_valid && bus_if.out_ready) act_q.push_back(bus_if.out_data);
                tick();
            end
            total++; if (act_q.size() == 0) begin bad++; $display("FAIL rnd_no_output run=%0d got=0 want=>0", run); end
            for (int i = 0; i < act_q.size(); i++) begin
                total++;
                if (i >= exp_q.size()) begin
                    bad++; $display("FAIL rnd_extra run=%0d idx=%0d got=%0d want=none", run, i, act_q[i]);
                end else if (act_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rnd_out run=%0d idx=%0d got=%0d want=%0d", run, i, act_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_bz();
        test_mul();
        test_in();
        test_out_stall();
        test_jmp_wrap();
        test_reset_mid_mul();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
